// File: rtl/park_pkg.sv
// Shared types and constants for the parking space allocator.
`timescale 1ns/1ps
package park_pkg;
    localparam int unsigned NUM_SPACES = 8;
    localparam int unsigned SPACE_W    = 3;
    localparam int unsigned COUNT_W    = 4;
    localparam logic [NUM_SPACES-1:0] INIT_FREE_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CLAIM,
        ST_GATE,
        ST_REJECT
    } park_state_t;

    function automatic logic [COUNT_W-1:0] popcount(input logic [NUM_SPACES-1:0] map);
        logic [COUNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_SPACES; i++) begin
            n = n + COUNT_W'(map[i]);
        end
        return n;
    endfunction
endpackage

// File: rtl/free_space_picker.sv
// Combinational lowest-free-space isolate and free-space popcount.
`timescale 1ns/1ps
module free_space_picker
    import park_pkg::*;
(
    input  logic [NUM_SPACES-1:0] pick_map,
    input  logic [NUM_SPACES-1:0] count_map,
    output logic [NUM_SPACES-1:0] lowest_c,
    output logic [COUNT_W-1:0]    count_c
);
    assign lowest_c = pick_map & (-pick_map);
    assign count_c  = popcount(count_map);
endmodule

// File: rtl/parking_space_allocator.sv
// Parking lot occupancy map, entry handshake FSM and exit path.
// Optional PARK_STATS_EN adds saturating grant/reject counters.
`timescale 1ns/1ps
module parking_space_allocator
    import park_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 4,
    parameter logic [NUM_SPACES-1:0] INIT_FREE = INIT_FREE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  car_arrive,
    output logic                  car_ack,
    output logic [SPACE_W-1:0]    assigned_space,
    output logic                  reject,
    input  logic                  car_leave,
    input  logic [SPACE_W-1:0]    leave_space,
    output logic                  leave_error,
    output logic [NUM_SPACES-1:0] space_onehot,
    output logic                  space_enable,
    input  logic [SPACE_W-1:0]    park_number,
    output logic [NUM_SPACES-1:0] free_map,
    output logic [COUNT_W-1:0]    free_count,
    output logic                  full,
    output logic                  empty,
`ifdef PARK_STATS_EN
    output logic [15:0]           entries_total,
    output logic [15:0]           rejects_total,
`endif
    output logic                  gate_open
);
    localparam int unsigned CNT_W = $clog2(GATE_CYCLES + 1);
    localparam logic [COUNT_W-1:0] INIT_COUNT = popcount(INIT_FREE);

    park_state_t             state;
    logic [CNT_W-1:0]        gate_cnt;
    logic [NUM_SPACES-1:0]   claim_clr_c;
    logic [NUM_SPACES-1:0]   leave_bit_c;
    logic [NUM_SPACES-1:0]   leave_set_c;
    logic                    leave_err_c;
    logic [NUM_SPACES-1:0]   map_next_c;
    logic [NUM_SPACES-1:0]   lowest_c;
    logic [COUNT_W-1:0]      count_next_c;

    // Next occupancy map: claim clears, a valid leave sets.
    always_comb begin
        claim_clr_c = '0;
        leave_set_c = '0;
        leave_bit_c = NUM_SPACES'(1) << leave_space;
        leave_err_c = car_leave && ((free_map & leave_bit_c) != '0);
        if (state == ST_CLAIM) begin
            claim_clr_c = NUM_SPACES'(1) << assigned_space;
        end
        if (car_leave && !leave_err_c) begin
            leave_set_c = leave_bit_c;
        end
        map_next_c = (free_map & ~claim_clr_c) | leave_set_c;
    end

    free_space_picker u_picker (
        .pick_map  (free_map),
        .count_map (map_next_c),
        .lowest_c  (lowest_c),
        .count_c   (count_next_c)
    );

    // Occupancy map and derived status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_map    <= INIT_FREE;
            free_count  <= INIT_COUNT;
            full        <= (INIT_COUNT == '0);
            empty       <= (INIT_COUNT == COUNT_W'(NUM_SPACES));
            leave_error <= 1'b0;
        end else begin
            free_map    <= map_next_c;
            free_count  <= count_next_c;
            full        <= (count_next_c == '0);
            empty       <= (count_next_c == COUNT_W'(NUM_SPACES));
            leave_error <= leave_err_c;
        end
    end

    // Entry handshake FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            car_ack        <= 1'b0;
            reject         <= 1'b0;
            assigned_space <= '0;
            space_onehot   <= '0;
            space_enable   <= 1'b0;
            gate_open      <= 1'b0;
            gate_cnt       <= '0;
        end else begin
            car_ack      <= 1'b0;
            reject       <= 1'b0;
            space_enable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (car_arrive && full) begin
                        reject <= 1'b1;
                        state  <= ST_REJECT;
                    end else if (car_arrive) begin
                        space_onehot <= lowest_c;
                        space_enable <= 1'b1;
                        state        <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    // A returned index pointing at a taken space means the encoder is broken.
                    if (free_map[park_number]) begin
                        assigned_space <= park_number;
                        car_ack        <= 1'b1;
                        state          <= ST_CLAIM;
                    end else begin
                        reject <= 1'b1;
                        state  <= ST_REJECT;
                    end
                end
                ST_CLAIM: begin
                    gate_open <= 1'b1;
                    gate_cnt  <= CNT_W'(GATE_CYCLES - 1);
                    state     <= ST_GATE;
                end
                ST_GATE: begin
                    if (gate_cnt != '0) begin
                        gate_cnt <= gate_cnt - CNT_W'(1);
                    end else begin
                        gate_open <= 1'b0;
                        if (!car_arrive) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_REJECT: begin
                    if (!car_arrive) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PARK_STATS_EN
    // Saturating grant and reject counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_total <= '0;
            rejects_total <= '0;
        end else begin
            if (car_ack && (entries_total != 16'hFFFF)) begin
                entries_total <= entries_total + 16'd1;
            end
            if (reject && (rejects_total != 16'hFFFF)) begin
                rejects_total <= rejects_total + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_parking_space_allocator.sv
// Randomized self-checking bench for parking_space_allocator with an occupancy reference model.
`timescale 1ns/1ps
module tb_parking_space_allocator;
    localparam int GATE = 4;

    logic       clk;
    logic       rst_n;
    logic       car_arrive;
    logic       car_ack;
    logic [2:0] assigned_space;
    logic       reject;
    logic       car_leave;
    logic [2:0] leave_space;
    logic       leave_error;
    logic [7:0] space_onehot;
    logic       space_enable;
    logic [2:0] park_number;
    logic [7:0] free_map;
    logic [3:0] free_count;
    logic       full;
    logic       empty;
    logic       gate_open;
`ifdef PARK_STATS_EN
    logic [15:0] entries_total;
    logic [15:0] rejects_total;
`endif

    int errors = 0;
    int checks = 0;
    bit model_free [8];
    int exp_entries = 0;
    int exp_rejects = 0;
    bit enc_fault = 1'b0;
    logic [2:0] fault_idx = '0;

    parking_space_allocator #(.GATE_CYCLES(GATE), .INIT_FREE(8'hFF)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .car_arrive     (car_arrive),
        .car_ack        (car_ack),
        .assigned_space (assigned_space),
        .reject         (reject),
        .car_leave      (car_leave),
        .leave_space    (leave_space),
        .leave_error    (leave_error),
        .space_onehot   (space_onehot),
        .space_enable   (space_enable),
        .park_number    (park_number),
        .free_map       (free_map),
        .free_count     (free_count),
        .full           (full),
        .empty          (empty),
`ifdef PARK_STATS_EN
        .entries_total  (entries_total),
        .rejects_total  (rejects_total),
`endif
        .gate_open      (gate_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the downstream one-hot encoder, with an optional fault override.
    always_comb begin
        park_number = '0;
        if (space_enable) begin
            for (int i = 0; i < 8; i++) begin
                if (space_onehot[i]) park_number = 3'(i);
            end
        end
        if (enc_fault) park_number = fault_idx;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_map();
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = model_free[i];
        return m;
    endfunction

    function automatic int model_count();
        int n = 0;
        foreach (model_free[i]) n += int'(model_free[i]);
        return n;
    endfunction

    function automatic int model_lowest();
        for (int i = 0; i < 8; i++) if (model_free[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        foreach (model_free[i]) model_free[i] = 1'b1;
        exp_entries = 0;
        exp_rejects = 0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_map"}, free_map, model_map());
        check({tag, "_count"}, free_count, model_count());
        check({tag, "_full"}, full, model_count() == 0);
        check({tag, "_empty"}, empty, model_count() == 8);
    endtask

    // One full entry transaction; optionally a leave is issued during the lookup cycle.
    task automatic do_entry(input bit leave_in_lookup, input int lsp);
        int lo, k, n, exp_lat;
        bit got_ack, got_rej;
        lo = model_lowest();
        @(negedge clk);
        car_arrive = 1'b1;
        k = 0; got_ack = 0; got_rej = 0;
        while (k < 12 && !got_ack && !got_rej) begin
            @(negedge clk);
            k++;
            if (k == 1 && lo >= 0) begin
                check("lookup_enable", space_enable, 1);
                check("lookup_onehot", space_onehot, 8'(1) << lo);
                if (leave_in_lookup) begin
                    car_leave = 1'b1;
                    leave_space = 3'(lsp);
                end
            end else begin
                car_leave = 1'b0;
            end
            got_ack = car_ack;
            got_rej = reject;
        end
        car_arrive = 1'b0;
        car_leave = 1'b0;
        if (!got_ack && !got_rej) check("arrive_timeout", 0, 1);
        if (lo < 0 || enc_fault) begin
            exp_lat = (lo < 0) ? 1 : 2;
            check("reject", got_rej, 1);
            check("reject_latency", k, exp_lat);
            check("no_ack", got_ack, 0);
            exp_rejects++;
            @(negedge clk);
            check("reject_pulse_end", reject, 0);
            check_status("after_reject");
        end else begin
            check("ack", got_ack, 1);
            check("ack_latency", k, 2);
            check("assigned_space", assigned_space, lo);
            model_free[lo] = 1'b0;
            if (leave_in_lookup) model_free[lsp] = 1'b1;
            exp_entries++;
            @(negedge clk);
            check("ack_pulse_end", car_ack, 0);
            check_status("after_claim");
            n = 0;
            while (gate_open && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("gate_cycles", n, GATE);
        end
    endtask

    task automatic do_leave(input int s);
        bit exp_err;
        exp_err = model_free[s];
        @(negedge clk);
        car_leave = 1'b1;
        leave_space = 3'(s);
        @(negedge clk);
        car_leave = 1'b0;
        check("leave_error", leave_error, exp_err);
        model_free[s] = 1'b1;
        check_status("after_leave");
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        car_arrive = 1'b0;
        car_leave = 1'b0;
        leave_space = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_status("reset");
        check("reset_ack", car_ack, 0);
        check("reset_gate", gate_open, 0);
        check("reset_onehot", space_onehot, 0);
        check("reset_assigned", assigned_space, 0);
        rst_n = 1'b1;

        // Fill the lot, then one refused entry.
        for (int i = 0; i < 9; i++) do_entry(1'b0, 0);
        check("full_flag", full, 1);

        // Full lot, free space 5 and take it again.
        do_leave(5);
        check("map_20", free_map, 8'h20);
        do_entry(1'b0, 0);

        // Claim of space 0 racing a leave of space 3.
        do_leave(0);
        do_entry(1'b1, 3);
        check("race_map", free_map, 8'h08);

        // Leave on an already-free space.
        pulse_reset();
        do_leave(2);
        check("err_map", free_map, 8'hFF);

        // Faulty encoder pointing at a taken space.
        do_entry(1'b0, 0);
        enc_fault = 1'b1;
        fault_idx = 3'd0;
        do_entry(1'b0, 0);
        enc_fault = 1'b0;

        // Reset asserted while the claim is in flight.
        pulse_reset();
        @(negedge clk);
        car_arrive = 1'b1;
        repeat (2) @(negedge clk);
        check("claim_ack_before_reset", car_ack, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_ack", car_ack, 0);
        check("rst_assigned", assigned_space, 0);
        check("rst_gate", gate_open, 0);
        check("rst_enable", space_enable, 0);
        check_status("rst_mid_claim");
        car_arrive = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Three grants and one refusal for the statistics counters.
        for (int i = 0; i < 3; i++) do_entry(1'b0, 0);
        enc_fault = 1'b1;
        fault_idx = 3'd1;
        do_entry(1'b0, 0);
        enc_fault = 1'b0;
`ifdef PARK_STATS_EN
        @(negedge clk);
        check("entries_total", entries_total, 3);
        check("rejects_total", rejects_total, 1);
`endif

        // Random mix of entries and leaves.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0) do_entry(1'b0, 0);
            else do_leave(int'($urandom_range(0, 7)));
        end
`ifdef PARK_STATS_EN
        @(negedge clk);
        check("entries_total_rand", entries_total, exp_entries);
        check("rejects_total_rand", rejects_total, exp_rejects);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
